// File: rtl/load_store_unit.sv
// Memory-access stage: runs one data-memory transaction at a time over a
// req/gnt/rvalid bus and returns aligned, extended load data or an error code.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  wb_err_q, wb_err_d;

  logic [16:0] cnt_inc;
  logic        timeout;

  function automatic logic f3_illegal(input logic is_ld, input logic [2:0] f3);
    if (is_ld) return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return f3 > 3'd2;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd1:    return a[0];
      2'd2:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0] a,
                                               input logic [2:0] f3);
    logic [31:0] s;
    s = rdata >> {a, 3'b000};
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'b0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign ex_ready = (state_q == S_IDLE);
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
  assign timeout  = cnt_inc >= 17'(MAX_WAIT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = 5'd0;
    wb_data_d    = 32'd0;
    wb_err_d     = ERR_OK;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          off_d = ex_addr[1:0];
          f3_d  = ex_funct3;
          rd_d  = ex_rd;
          // Both flags set is treated as a load, so ex_load alone decides direction.
          if (!ex_load && !ex_store) begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
          end else if (f3_illegal(ex_load, ex_funct3)) begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_err_d   = ERR_FUNCT3;
          end else if (misaligned(ex_funct3[1:0], ex_addr[1:0])) begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_err_d   = ERR_MISALIGN;
          end else begin
            state_d      = S_REQ;
            cnt_d        = 16'd0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = !ex_load;
            dmem_addr_d  = {ex_addr[31:2], 2'b00};
            dmem_be_d    = ex_load ? 4'b1111 : store_be(ex_funct3[1:0], ex_addr[1:0]);
            dmem_wdata_d = ex_load ? 32'd0 : store_data(ex_funct3[1:0], ex_wdata);
          end
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_inc[15:0];
        // Timeout wins over a same-cycle gnt/rvalid so the bound is exact.
        if (timeout) begin
          state_d    = S_RESP;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_err_d   = ERR_TIMEOUT;
        end else if (state_q == S_REQ) begin
          if (dmem_gnt) begin
            state_d    = S_WAIT;
            dmem_req_d = 1'b0;
          end
        end else if (dmem_rvalid) begin
          state_d    = S_RESP;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (!dmem_we_q) begin
            wb_data_d = load_extract(dmem_rdata, off_q, f3_q);
            wb_we_d   = (rd_q != 5'd0);
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      off_q        <= 2'd0;
      f3_q         <= 3'd0;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'd0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_err_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_err     = wb_err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU-computed effective address (alu_result for LB/LH/LW/LBU/LHU/SB/SH/SW), the store data and the destination register. It then runs one transaction on a variable-latency data-memory bus with a req/gnt/rvalid handshake. It returns aligned, sign- or zero-extended load data, or an error code, to writeback. It handles one transaction at a time and is not pipelined.

Parameters:
MAX_WAIT, 255, maximum number of cycles spent in REQ plus WAIT before the transaction is abandoned with a timeout; legal range 2..65535.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an operation
ex_ready  out  1  unit can accept an operation this cycle
ex_load  in  1  operation is a load
ex_store  in  1  operation is a store
ex_funct3  in  3  RISC-V funct3 (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU)
ex_addr  in  32  effective address from the ALU
ex_wdata  in  32  store data (rs2)
ex_rd  in  5  destination register
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_be  out  4  byte enables
dmem_addr  out  32  word address, bits [1:0] = 0
dmem_wdata  out  32  lane-replicated write data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response valid (sent for both loads and stores)
dmem_rdata  in  32  read data
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  write wb_data to wb_rd
wb_rd  out  5  destination register
wb_data  out  32  load result
wb_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All outputs are registered except ex_ready.
- ex_ready = (state == IDLE).
- Reset values: all outputs 0 except ex_ready = 1; state = IDLE; wait counter = 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on ex_valid && ex_ready, capture the operation (address, data, rd, funct3, load/store flags).
  - Neither ex_load nor ex_store set: go to RESP, wb_we = 0, wb_err = 00.
  - Both set: treat as a load.
  - Illegal funct3 (loads: 3, 6, 7; stores: anything other than 0, 1, 2): go to RESP, wb_err = 10.
  - Misaligned (halfword with addr[0] = 1, word with addr[1:0] != 0): go to RESP, wb_err = 01. No bus access is made.
  - Otherwise: go to REQ.
- REQ: dmem_req = 1. dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable until dmem_gnt is sampled high, then go to WAIT. dmem_req drops in the cycle after gnt.
- WAIT: on dmem_rvalid, go to RESP. The earliest legal rvalid is the cycle after gnt; rvalid in the same cycle as gnt is not a legal bus behaviour.
- RESP: wb_valid = 1 for exactly one cycle, then IDLE. Back-to-back accepts are allowed on the following cycle.
- Store byte enables, with a = addr[1:0]:
  - SB: be = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011 << a; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata unchanged.
- Loads: be = 4'b1111. Let s = rdata >> (8*a).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: rdata.
- wb_we = 1 only for a successful load with rd != 0. wb_rd always echoes the captured rd. wb_data = 0 for stores and errors.
- Timeout: the counter resets on entry to REQ and increments every cycle in REQ or WAIT. When it reaches MAX_WAIT, go to RESP with wb_err = 11, dmem_req = 0 and wb_we = 0.
- Stray bus signals: dmem_gnt or dmem_rvalid arriving in IDLE or RESP is ignored.
- Latency: accept in cycle T gives dmem_req at T+1. With gnt at T+1 and rvalid at T+2, wb_valid is at T+3. Error and non-memory paths give wb_valid at T+1.
- Reset mid-transaction: immediately return to IDLE, drop dmem_req, clear wb_valid. A later rvalid is ignored.

Test Plan:
- LW at addr 0x100; gnt at T+1, rvalid at T+2, rdata 0xDEADBEEF: dmem_addr 0x100, be 1111, wb_valid at T+3, wb_data 0xDEADBEEF, wb_we 1.
- LB at 0x103 with rdata 0x80FF_0000 gives wb_data 0xFFFFFF80; LBU at the same address gives 0x00000080; LHU at 0x102 gives 0x000080FF.
- SH at 0x206 with wdata 0x1234ABCD: dmem_addr 0x204, be 1100, dmem_wdata 0xABCDABCD, we 1. gnt is held off 3 cycles; req and payload stay stable throughout. Then wb_valid with wb_we 0.
- LW at 0x102: no dmem_req, wb_valid at T+1, wb_err 01. Load with funct3 = 3: wb_err 10. Load to rd = 0 succeeds with wb_we 0.
- MAX_WAIT = 4, gnt never asserted: wb_valid with wb_err 11 four cycles after entering REQ, dmem_req low after. A later rvalid pulse is ignored.
- Assert rst_n low while in WAIT: outputs reach reset values asynchronously; ex_ready = 1 after release; the stale rvalid produces no wb_valid.
